// File: rtl/rr_req_encoder.sv
// rr_req_encoder
//   Round-robin request encoder. Request pulses on req[N-1:0] are latched as
//   sticky pending bits; pending lines are granted one at a time as a
//   registered binary index plus its one-hot echo, under a valid/ready
//   handshake.
//
// Ports
//   clock         rising-edge clock
//   ctrl_reset_n  asynchronous active-low reset
//   req           request pulses, ORed into pending
//   flush         synchronous clear of pending, pointer and grant
//   out_ready     consumer accepts the current grant
//   out_valid     grant present
//   out_index     binary index of granted line
//   out_onehot    one-hot of out_index while out_valid, else 0
//   pending_any   OR of the pending register
module rr_req_encoder #(
    parameter int N  = 32,
    parameter int IW = 5
) (
    input  logic          clock,
    input  logic          ctrl_reset_n,
    input  logic [N-1:0]  req,
    input  logic          flush,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_index,
    output logic [N-1:0]  out_onehot,
    output logic          pending_any
);

    logic [N-1:0]  pending;
    logic [IW-1:0] ptr;

    logic          accept;
    logic          load;
    logic [N-1:0]  acc_mask;
    logic [N-1:0]  srch;
    logic [IW-1:0] nxt_idx;
    logic [IW-1:0] start;
    logic [N-1:0]  srch_rot;
    logic [IW-1:0] rot_idx;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_onehot;

    assign accept   = out_valid & out_ready;
    // out_onehot already equals onehot(out_index) whenever out_valid is high
    assign acc_mask = accept ? out_onehot : '0;
    // Search sees registered pending only; this cycle's req is not visible
    assign srch     = pending & ~acc_mask;
    assign nxt_idx  = out_index + 1'b1;
    assign start    = accept ? nxt_idx : ptr;
    assign load     = ~out_valid | accept;

    // Rotate the search set so that bit 'start' lands at position 0; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign srch_rot = N'({srch, srch} >> start);

    always_comb begin
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (srch_rot[i]) rot_idx = IW'(i);
        end
    end

    // N == 2**IW, so the IW-bit add wraps modulo N for free
    assign win_idx = start + rot_idx;

    generate
        for (genvar g = 0; g < N; g++) begin : g_oh
            assign win_onehot[g] = (win_idx == IW'(g));
        end
    endgenerate

    assign pending_any = |pending;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            pending    <= '0;
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_onehot <= '0;
        end else if (flush) begin
            // out_index intentionally holds across a flush
            pending    <= '0;
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_onehot <= '0;
        end else begin
            // Set wins: a line re-requested in its accept cycle stays pending
            pending <= srch | req;
            if (accept) ptr <= nxt_idx;
            // In HOLD without accept the grant is frozen, no re-arbitration
            if (load) begin
                if (|srch) begin
                    out_valid  <= 1'b1;
                    out_index  <= win_idx;
                    out_onehot <= win_onehot;
                end else begin
                    out_valid  <= 1'b0;
                    out_onehot <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_req_encoder.sv
module tb_rr_req_encoder;
    localparam int N  = 32;
    localparam int IW = 5;

    logic          clock = 1'b0;
    logic          ctrl_reset_n;
    logic [N-1:0]  req;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [IW-1:0] out_index;
    logic [N-1:0]  out_onehot;
    logic          pending_any;

    rr_req_encoder #(.N(N), .IW(IW)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .req          (req),
        .flush        (flush),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_index    (out_index),
        .out_onehot   (out_onehot),
        .pending_any  (pending_any)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Reference model: pending as a bit set, pointer and index as integers
    bit [N-1:0] m_pending;
    int         m_ptr;
    int         m_index;
    bit         m_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pending = '0;
        m_ptr     = 0;
        m_index   = 0;
        m_valid   = 0;
    endtask

    // One clock of the behavioural rules
    task automatic model_clk(input bit [N-1:0] r, input bit fl, input bit rdy);
        bit         acc;
        bit [N-1:0] s;
        int         st;
        bit         found;
        acc = m_valid && rdy;
        s   = m_pending;
        if (acc) s[m_index] = 1'b0;
        st = acc ? (m_index + 1) % N : m_ptr;
        if (fl) begin
            m_pending = '0;
            m_ptr     = 0;
            m_valid   = 0;
        end else begin
            m_pending = s | r;
            if (acc) m_ptr = (m_index + 1) % N;
            if (!m_valid || acc) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && s[(st + k) % N]) begin
                        found   = 1;
                        m_index = (st + k) % N;
                    end
                end
                m_valid = found;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] exp_oh;
        exp_oh = m_valid ? (64'd1 << m_index) : 64'd0;
        check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".index"}, 64'(out_index), 64'(m_index));
        check({tag, ".onehot"}, 64'(out_onehot), exp_oh);
        check({tag, ".pend_any"}, 64'(pending_any), 64'(|m_pending));
    endtask

    // Apply inputs for one cycle, advance model, sample 1 time unit after the edge
    task automatic cyc(input logic [N-1:0] r, input logic fl, input logic rdy);
        req       = r;
        flush     = fl;
        out_ready = rdy;
        model_clk(r, fl, rdy);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit [N-1:0] rr;
        bit         rf;
        bit         rrdy;

        req = '0; flush = 1'b0; out_ready = 1'b0; ctrl_reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        check("reset.valid0", 64'(out_valid), 64'd0);
        ctrl_reset_n = 1'b1;

        // Single request, held under backpressure, then accepted
        cyc(32'h0000_0080, 1'b0, 1'b0);
        check_all("sr_latch");
        check("sr_latch.novalid", 64'(out_valid), 64'd0);
        cyc('0, 1'b0, 1'b0);
        check_all("sr_grant");
        check("sr_grant.idx", 64'(out_index), 64'd7);
        check("sr_grant.oh", 64'(out_onehot), 64'h80);
        repeat (3) begin
            cyc('0, 1'b0, 1'b0);
            check_all("sr_hold");
            check("sr_hold.idx", 64'(out_index), 64'd7);
        end
        cyc('0, 1'b0, 1'b1);
        check_all("sr_acc");
        check("sr_acc.valid", 64'(out_valid), 64'd0);
        check("sr_acc.pend", 64'(pending_any), 64'd0);

        // Round robin from ptr=0 with back-to-back grants
        cyc('0, 1'b1, 1'b0);
        check_all("rr_flush");
        cyc(32'h8000_0011, 1'b0, 1'b1);
        check_all("rr_latch");
        cyc('0, 1'b0, 1'b1);
        check_all("rr_g0");
        check("rr_g0.idx", 64'(out_index), 64'd0);
        cyc('0, 1'b0, 1'b1);
        check_all("rr_g4");
        check("rr_g4.idx", 64'(out_index), 64'd4);
        cyc('0, 1'b0, 1'b1);
        check_all("rr_g31");
        check("rr_g31.idx", 64'(out_index), 64'd31);
        cyc('0, 1'b0, 1'b1);
        check_all("rr_done");
        check("rr_done.valid", 64'(out_valid), 64'd0);

        // Move ptr to 8 via a grant on line 7, then wrapping search
        cyc(32'h0000_0080, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        check_all("wr_pre");
        cyc('0, 1'b0, 1'b1);
        check_all("wr_ptr8");
        cyc(32'h0010_0008, 1'b0, 1'b1);
        check_all("wr_latch");
        cyc('0, 1'b0, 1'b1);
        check_all("wr_g20");
        check("wr_g20.idx", 64'(out_index), 64'd20);
        cyc('0, 1'b0, 1'b1);
        check_all("wr_g3");
        check("wr_g3.idx", 64'(out_index), 64'd3);
        cyc('0, 1'b0, 1'b1);
        check_all("wr_done");
        // ptr must now be 4: with lines 3 and 5 pending, 5 wins
        cyc(32'h0000_0028, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        check_all("wr_ptr4");
        check("wr_ptr4.idx", 64'(out_index), 64'd5);
        cyc('0, 1'b0, 1'b1);
        check_all("wr_drain3");
        check("wr_drain3.idx", 64'(out_index), 64'd3);
        cyc('0, 1'b0, 1'b1);
        check_all("wr_empty");

        // Set-wins collision on line 5
        cyc(32'h0000_0020, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);
        check_all("sw_g5");
        check("sw_g5.idx", 64'(out_index), 64'd5);
        cyc(32'h0000_0020, 1'b0, 1'b1);
        check_all("sw_gap");
        check("sw_gap.valid", 64'(out_valid), 64'd0);
        check("sw_gap.pend", 64'(pending_any), 64'd1);
        cyc('0, 1'b0, 1'b0);
        check_all("sw_regrant");
        check("sw_regrant.idx", 64'(out_index), 64'd5);
        check("sw_regrant.valid", 64'(out_valid), 64'd1);
        cyc('0, 1'b0, 1'b1);
        check_all("sw_done");

        // Flush during HOLD on line 12
        cyc(32'h0000_F000, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check_all("fl_hold");
        check("fl_hold.idx", 64'(out_index), 64'd12);
        cyc(32'h0000_0001, 1'b1, 1'b0);
        check_all("fl_flush");
        check("fl_flush.valid", 64'(out_valid), 64'd0);
        check("fl_flush.pend", 64'(pending_any), 64'd0);
        check("fl_flush.idx_hold", 64'(out_index), 64'd12);
        cyc('0, 1'b0, 1'b1);
        check_all("fl_after");
        check("fl_after.valid", 64'(out_valid), 64'd0);

        // Asynchronous reset in HOLD on line 9, no clock edge involved
        cyc(32'h0000_0200, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check_all("ar_hold");
        check("ar_hold.idx", 64'(out_index), 64'd9);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        check("ar.valid", 64'(out_valid), 64'd0);
        check("ar.index", 64'(out_index), 64'd0);
        check("ar.onehot", 64'(out_onehot), 64'd0);
        check("ar.pend", 64'(pending_any), 64'd0);
        model_reset();
        #1;
        ctrl_reset_n = 1'b1;
        repeat (2) begin
            cyc('0, 1'b0, 1'b1);
            check_all("ar_after");
            check("ar_after.valid", 64'(out_valid), 64'd0);
        end

        // Randomised traffic against the model
        for (int t = 0; t < 600; t++) begin
            rr   = ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom & $urandom) : '0;
            rf   = ($urandom_range(0, 39) == 0);
            rrdy = ($urandom_range(0, 3) != 0);
            cyc(rr, rf, rrdy);
            check_all("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_req_encoder.md
Name: rr_req_encoder

Overview:
- Converts a 32-bit vector of one-hot/multi-hot request pulses (e.g. per-register or per-source event lines) into a registered 5-bit binary index plus its one-hot echo.
- Works in the opposite direction to the register-select decoder.
- Requests are latched as sticky pending bits and granted one at a time, in round-robin order.
- Grants use a valid/ready handshake, so a downstream consumer (writeback sequencer, interrupt unit) can apply backpressure.

Parameters:
- N, 32, number of request lines; must equal 2**IW.
- IW, 5, index width.

Ports:
- clock  input  1  rising-edge clock.
- ctrl_reset_n  input  1  asynchronous, active-low reset.
- req  input  N  request pulses; each set bit is ORed into pending.
- flush  input  1  synchronous clear of pending, output and pointer.
- out_ready  input  1  consumer accepts the current grant.
- out_valid  output  1  grant present.
- out_index  output  IW  binary index of granted line.
- out_onehot  output  N  one-hot of out_index when out_valid=1; 0 otherwise.
- pending_any  output  1  OR of the pending register.

Behaviour:
- Reset (ctrl_reset_n=0, asynchronous, at any time including mid-grant):
  - pending=0, ptr=0.
  - out_valid=0, out_index=0, out_onehot=0, pending_any=0.
- State: pending[N-1:0], ptr[IW-1:0], plus output registers. Two implicit states:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- accept = out_valid & out_ready.
- acc_mask = onehot(out_index) if accept, else 0.
- pending update each cycle: pending <= (pending & ~acc_mask) | req.
  - A req bit asserted in the same cycle its grant is accepted stays pending (set wins).
- Search set: S = pending & ~acc_mask. This uses registered pending only; req arriving this cycle is not visible to the search.
- Search start: start = out_index+1 (mod N, natural IW-bit wrap) if accept, else ptr.
- Winner: first set bit of S scanning start, start+1, …, N-1, 0, …, start-1.
- Load condition: load = ~out_valid | accept.
  - If load and S!=0: out_valid<=1, out_index<=winner, out_onehot<=onehot(winner).
  - If load and S==0: out_valid<=0, out_onehot<=0, out_index holds.
- ptr update: on accept, ptr <= out_index+1 (wraps 31→0); otherwise ptr holds.
- HOLD with out_ready=0: out_index and out_onehot held stable, no re-arbitration, even if higher-priority bits arrive.
- Latency:
  - req pulse to out_valid from IDLE: 2 cycles (cycle N latch, N+1 search, valid at N+2 edge).
  - Back-to-back grants: 1 per cycle while S is non-empty and out_ready=1.
- Accepted bit re-requested: it is excluded from the search in the accept cycle. It becomes eligible from the next cycle, and is reached again only after the pointer wraps or no other bits remain.
- flush=1 (synchronous, overrides req and accept):
  - pending<=0, ptr<=0, out_valid<=0, out_onehot<=0, out_index holds.
- pending_any = |pending (combinational from the register).
- No drop or overflow: each line holds at most one pending request; repeated pulses before grant merge.

Test Plan:
- Reset: drive ctrl_reset_n=0 asynchronously mid-HOLD (out_index=9) -> all outputs 0 immediately, with no clock edge needed; after release and no req, out_valid stays 0.
- Single request: req=0x0000_0080 for one cycle, out_ready=0 -> out_valid=1, out_index=7, out_onehot=0x80 two edges later. Hold 3 cycles stable; raise out_ready -> next cycle out_valid=0, ptr=8, pending=0.
- Round robin / back-to-back: from ptr=0, req=0x8000_0011 one cycle, out_ready=1 -> grants 0, 4, 31 on three consecutive cycles, then out_valid=0, ptr=0 (wrap).
- Wrap search: ptr=8, req=0x0010_0008 -> grant 20 then 3; ptr ends at 4.
- Set-wins collision: bit 5 granted and accepted while req[5]=1 in the same cycle, no other pending -> out_valid=0 for one cycle, then out_index=5 again.
- Flush: pending=0x0000_F000, HOLD on 12, assert flush with req=0x1 -> next cycle out_valid=0, pending=0, ptr=0, pending_any=0.
